// File: rtl/psm_pkg.sv
// Shared encodings and helpers for the PWM/PSM regulation controller.
// Mode codes and the threshold clamp used by the sample pipeline.
package psm_pkg;

  localparam logic [1:0] MODE_PWM  = 2'd0;
  localparam logic [1:0] MODE_PSM  = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  function automatic int clamp_th(input int v, input int maxv);
    if (v < 0)
      return 0;
    if (v > maxv)
      return maxv;
    return v;
  endfunction

endpackage

// File: rtl/psm_mode_ctrl_if.sv
// Streamed ADC sample bus (one-cycle valid strobe, no backpressure).
// master drives sample_valid/sample, slave consumes them.
interface psm_mode_ctrl_if #(
  parameter int ADC_W = 12
) ();

  logic             sample_valid;
  logic [ADC_W-1:0] sample;

  modport master (
    output sample_valid,
    output sample
  );

  modport slave (
    input sample_valid,
    input sample
  );

endinterface

// File: rtl/psm_pwm_gen.sv
// Free-running PWM counter with wrap strobe and duty captured at wrap.
// Ports: clk, rst_n, duty in; wrap (cnt==max) and raw (cnt<duty_q) out.
module psm_pwm_gen #(
  parameter int RESOLUTION = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RESOLUTION-1:0] duty,
  output logic                  wrap,
  output logic                  raw
);

  logic [RESOLUTION-1:0] cnt_q;
  logic [RESOLUTION-1:0] cnt_d;
  logic [RESOLUTION-1:0] duty_q;
  logic [RESOLUTION-1:0] duty_d;

  always_comb begin
    wrap   = (cnt_q == '1);
    cnt_d  = cnt_q + 1'b1;
    duty_d = wrap ? duty : duty_q;
    raw    = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

endmodule

// File: rtl/psm_mode_ctrl.sv
// PWM/PSM regulation controller: adaptive hysteresis, auto boost, gating.
// Ports: clk, rst_n, smp (sample bus), duty, mode, cnt_clr in; gate_out, burst_en, boost_active, low_th, high_th, skip_count out.
module psm_mode_ctrl
  import psm_pkg::*;
#(
  parameter int RESOLUTION = 9,
  parameter int ADC_W      = 12,
  parameter int V_REF      = 3730,
  parameter int BASE_LOW   = 3610,
  parameter int BASE_HIGH  = 3644,
  parameter int SH_LO      = 2,
  parameter int SH_HI      = 3,
  parameter int EMERG_ERR  = 128,
  parameter int ENTER_CNT  = 4,
  parameter int EXIT_CNT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  psm_mode_ctrl_if.slave        smp,
  input  logic [RESOLUTION-1:0] duty,
  input  logic [1:0]            mode,
  input  logic                  cnt_clr,
  output logic                  gate_out,
  output logic                  burst_en,
  output logic                  boost_active,
  output logic [ADC_W-1:0]      low_th,
  output logic [ADC_W-1:0]      high_th,
  output logic [15:0]           skip_count
);

  localparam int MAXV    = (2 ** ADC_W) - 1;
  localparam int CNT_MAX = (ENTER_CNT > EXIT_CNT) ? ENTER_CNT : EXIT_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic signed [ADC_W:0]   VREF_S  = (ADC_W+1)'(V_REF);
  localparam logic signed [ADC_W:0]   EMERG_S = (ADC_W+1)'(EMERG_ERR);
  localparam logic signed [ADC_W:0]   HALF_S  = (ADC_W+1)'(EMERG_ERR / 2);
  localparam logic signed [ADC_W+1:0] BLO_S   = (ADC_W+2)'(BASE_LOW);
  localparam logic signed [ADC_W+1:0] BHI_S   = (ADC_W+2)'(BASE_HIGH);
  localparam logic [CW-1:0]           ENTER_C = CW'(ENTER_CNT);
  localparam logic [CW-1:0]           EXIT_C  = CW'(EXIT_CNT);

  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_BOOST  = 1'b1;

  logic wrap;
  logic raw;

  psm_pwm_gen #(
    .RESOLUTION(RESOLUTION)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (duty),
    .wrap (wrap),
    .raw  (raw)
  );

  logic                    v1_q, v1_d;
  logic [ADC_W-1:0]        smp_q, smp_d;
  logic signed [ADC_W:0]   err_q, err_d;
  logic [ADC_W-1:0]        low_q, low_d;
  logic [ADC_W-1:0]        high_q, high_d;
  logic                    burst_q, burst_d;
  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           emerg_q, emerg_d;
  logic [CW-1:0]           rec_q, rec_d;
  logic [1:0]              mode_q, mode_d;
  logic                    gate_q, gate_d;
  logic                    gate_out_q, gate_out_d;
  logic [15:0]             skip_q, skip_d;

  logic signed [ADC_W:0]   err_n;
  logic signed [ADC_W+1:0] err_x;
  logic signed [ADC_W+1:0] lo_raw;
  logic signed [ADC_W+1:0] hi_raw;
  logic                    boost;
  logic                    gate_sel;

  assign boost = (state_q == S_BOOST);

  // Stage 1: error and error-adaptive thresholds
  always_comb begin
    err_n  = VREF_S - $signed({1'b0, smp.sample});
    err_x  = {err_n[ADC_W], err_n};
    lo_raw = BLO_S - (err_x >>> SH_LO);
    hi_raw = BHI_S - (err_x >>> SH_HI);
    v1_d   = smp.sample_valid;
    smp_d  = smp_q;
    err_d  = err_q;
    low_d  = low_q;
    high_d = high_q;
    if (smp.sample_valid) begin
      smp_d  = smp.sample;
      err_d  = err_n;
      low_d  = ADC_W'(clamp_th(int'(lo_raw), MAXV));
      high_d = ADC_W'(clamp_th(int'(hi_raw), MAXV));
    end
  end

  // Stage 2: hysteresis and boost FSM, both per registered sample
  always_comb begin
    burst_d = burst_q;
    state_d = state_q;
    emerg_d = emerg_q;
    rec_d   = rec_q;
    if (v1_q) begin
      if (smp_q < low_q)
        burst_d = 1'b1;
      else if (smp_q > high_q)
        burst_d = 1'b0;
    end
    if (mode_q != MODE_AUTO) begin
      state_d = S_NORMAL;
      emerg_d = '0;
      rec_d   = '0;
    end else if (v1_q) begin
      unique case (state_q)
        S_NORMAL: begin
          if (err_q > EMERG_S) begin
            emerg_d = (emerg_q == '1) ? emerg_q : emerg_q + 1'b1;
            if (emerg_d >= ENTER_C) begin
              state_d = S_BOOST;
              emerg_d = '0;
            end
          end else begin
            emerg_d = '0;
          end
        end
        S_BOOST: begin
          if (err_q < HALF_S) begin
            rec_d = (rec_q == '1) ? rec_q : rec_q + 1'b1;
            if (rec_d >= EXIT_C) begin
              state_d = S_NORMAL;
              rec_d   = '0;
              emerg_d = '0;
            end
          end else begin
            rec_d = '0;
          end
        end
        default: state_d = S_NORMAL;
      endcase
    end
  end

  // Gate decision uses the mode being captured at this wrap
  always_comb begin
    gate_sel = 1'b0;
    unique case (1'b1)
      (mode == MODE_PWM):  gate_sel = 1'b1;
      (mode == MODE_PSM):  gate_sel = burst_q;
      (mode == MODE_AUTO): gate_sel = burst_q | boost;
      (mode == MODE_OFF):  gate_sel = 1'b0;
      default:             gate_sel = 1'b0;
    endcase
  end

  always_comb begin
    mode_d     = wrap ? mode : mode_q;
    gate_d     = wrap ? gate_sel : gate_q;
    gate_out_d = raw & gate_q;
    skip_d     = skip_q;
    if (cnt_clr)
      skip_d = '0;
    else if (wrap && !gate_sel && (mode != MODE_OFF) && (skip_q != 16'hFFFF))
      skip_d = skip_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      smp_q      <= '0;
      err_q      <= '0;
      low_q      <= '0;
      high_q     <= '0;
      burst_q    <= 1'b0;
      state_q    <= S_NORMAL;
      emerg_q    <= '0;
      rec_q      <= '0;
      mode_q     <= MODE_PWM;
      gate_q     <= 1'b0;
      gate_out_q <= 1'b0;
      skip_q     <= '0;
    end else begin
      v1_q       <= v1_d;
      smp_q      <= smp_d;
      err_q      <= err_d;
      low_q      <= low_d;
      high_q     <= high_d;
      burst_q    <= burst_d;
      state_q    <= state_d;
      emerg_q    <= emerg_d;
      rec_q      <= rec_d;
      mode_q     <= mode_d;
      gate_q     <= gate_d;
      gate_out_q <= gate_out_d;
      skip_q     <= skip_d;
    end
  end

  assign gate_out     = gate_out_q;
  assign burst_en     = burst_q;
  assign boost_active = boost;
  assign low_th       = low_q;
  assign high_th      = high_q;
  assign skip_count   = skip_q;

endmodule
